// File: rtl/ctrl_pipe_regs.sv
// Control-bundle pipeline registers for ID/EX, EX/MEM and MEM/WB.
// Also handles load-use stalls, branch/jump squashes and saturating event counters.
module ctrl_pipe_regs #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_RegDst,
    input  logic             id_ALUSrc,
    input  logic             id_MemtoReg,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_Branch,
    input  logic             id_Jump,
    input  logic [1:0]       id_ALUOp,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rt,
    input  logic             mem_zero,
    output logic             ex_ALUSrc,
    output logic             ex_RegDst,
    output logic [1:0]       ex_ALUOp,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic             wb_MemtoReg,
    output logic             wb_RegWrite,
    output logic [REG_W-1:0] wb_wreg,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
    logic [REG_W-1:0] ex_wreg;
    logic             mem_MemtoReg, mem_RegWrite, mem_Branch_int, mem_Jump_int;
    logic [REG_W-1:0] mem_wreg;
    logic             hz;
    logic             id_bubble;
    logic [REG_W-1:0] id_wreg;

    // Hazard detection and branch resolution; a squash overrides a stall.
    always_comb begin
        hz        = id_valid & ex_MemRead & (ex_wreg != '0) &
                    ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));
        flush     = (mem_Branch_int & mem_zero) | mem_Jump_int;
        stall     = hz & ~flush;
        id_bubble = ~id_valid | stall | flush;
        id_wreg   = id_RegDst ? id_rd : id_rt;
    end

    // ID/EX: bubble on invalid, stalled or squashed ID; wreg cleared without RegWrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || id_bubble) begin
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_Jump     <= 1'b0;
            ex_wreg     <= '0;
        end else begin
            ex_RegDst   <= id_RegDst;
            ex_ALUSrc   <= id_ALUSrc;
            ex_ALUOp    <= id_ALUOp;
            ex_MemtoReg <= id_MemtoReg;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_Branch   <= id_Branch;
            ex_Jump     <= id_Jump;
            ex_wreg     <= id_RegWrite ? id_wreg : '0;
        end
    end

    // EX/MEM: the instruction in EX is younger than a resolving branch, so squash it too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mem_MemtoReg   <= 1'b0;
            mem_RegWrite   <= 1'b0;
            mem_MemRead    <= 1'b0;
            mem_MemWrite   <= 1'b0;
            mem_Branch_int <= 1'b0;
            mem_Jump_int   <= 1'b0;
            mem_wreg       <= '0;
        end else begin
            mem_MemtoReg   <= ex_MemtoReg;
            mem_RegWrite   <= ex_RegWrite;
            mem_MemRead    <= ex_MemRead;
            mem_MemWrite   <= ex_MemWrite;
            mem_Branch_int <= ex_Branch;
            mem_Jump_int   <= ex_Jump;
            mem_wreg       <= ex_wreg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_MemtoReg <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_wreg     <= '0;
        end else begin
            wb_MemtoReg <= mem_MemtoReg;
            wb_RegWrite <= mem_RegWrite;
            wb_wreg     <= mem_wreg;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Scoreboard bench for ctrl_pipe_regs: directed hazard/branch cases plus random stream.
`timescale 1ns/1ps
module tb_ctrl_pipe_regs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0, id_RegDst = 1'b0, id_ALUSrc = 1'b0, id_MemtoReg = 1'b0;
    logic id_RegWrite = 1'b0, id_MemRead = 1'b0, id_MemWrite = 1'b0, id_Branch = 1'b0, id_Jump = 1'b0;
    logic [1:0] id_ALUOp = 2'b00;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic id_uses_rt = 1'b0, mem_zero = 1'b0;

    logic ex_ALUSrc, ex_RegDst, mem_MemRead, mem_MemWrite, wb_MemtoReg, wb_RegWrite, stall, flush;
    logic [1:0] ex_ALUOp;
    logic [4:0] wb_wreg;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter instance on the same stimulus, to reach saturation quickly.
    logic s_ex_ALUSrc, s_ex_RegDst, s_mem_MemRead, s_mem_MemWrite, s_wb_MemtoReg, s_wb_RegWrite, s_stall, s_flush;
    logic [1:0] s_ex_ALUOp;
    logic [4:0] s_wb_wreg;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    ctrl_pipe_regs dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
        .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt), .mem_zero(mem_zero),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp), .mem_MemRead(mem_MemRead),
        .mem_MemWrite(mem_MemWrite), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
        .wb_wreg(wb_wreg), .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipe_regs #(.REG_W(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
        .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt), .mem_zero(mem_zero),
        .ex_ALUSrc(s_ex_ALUSrc), .ex_RegDst(s_ex_RegDst), .ex_ALUOp(s_ex_ALUOp), .mem_MemRead(s_mem_MemRead),
        .mem_MemWrite(s_mem_MemWrite), .wb_MemtoReg(s_wb_MemtoReg), .wb_RegWrite(s_wb_RegWrite),
        .wb_wreg(s_wb_wreg), .stall(s_stall), .flush(s_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic       RegDst, ALUSrc;
        logic [1:0] ALUOp;
        logic       MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
        logic [4:0] wreg;
    } ctl_t;

    typedef struct packed {
        logic        ex_ALUSrc, ex_RegDst;
        logic [1:0]  ex_ALUOp;
        logic        mem_MemRead, mem_MemWrite, wb_MemtoReg, wb_RegWrite;
        logic [4:0]  wb_wreg;
        logic        stall, flush;
        logic [15:0] stall_cnt, flush_cnt;
        logic [1:0]  s_stall_cnt, s_flush_cnt;
    } obs_t;

    localparam int KR = 0, KADDIU = 1, KLW = 2, KSW = 3, KBEQ = 4, KJ = 5, KBUB = 6;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: instruction bundles in EX, MEM, WB and event totals.
    ctl_t pipe [3];
    int   n_stall, n_flush;

    function automatic obs_t sample();
        obs_t a;
        a.ex_ALUSrc = ex_ALUSrc;     a.ex_RegDst = ex_RegDst;       a.ex_ALUOp = ex_ALUOp;
        a.mem_MemRead = mem_MemRead; a.mem_MemWrite = mem_MemWrite;
        a.wb_MemtoReg = wb_MemtoReg; a.wb_RegWrite = wb_RegWrite;   a.wb_wreg = wb_wreg;
        a.stall = stall;             a.flush = flush;
        a.stall_cnt = stall_cnt;     a.flush_cnt = flush_cnt;
        a.s_stall_cnt = s_stall_cnt; a.s_flush_cnt = s_flush_cnt;
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        n_stall = 0;
        n_flush = 0;
    endtask

    task automatic drive_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic mz);
        id_valid = 1'b1; id_RegDst = 1'b0; id_ALUSrc = 1'b0; id_ALUOp = 2'b00; id_MemtoReg = 1'b0;
        id_RegWrite = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0; id_Branch = 1'b0; id_Jump = 1'b0;
        id_uses_rt = 1'b0;
        case (kind)
            KR:     begin id_RegDst = 1'b1; id_ALUOp = 2'b10; id_RegWrite = 1'b1; id_uses_rt = 1'b1; end
            KADDIU: begin id_ALUSrc = 1'b1; id_RegWrite = 1'b1; end
            KLW:    begin id_ALUSrc = 1'b1; id_MemtoReg = 1'b1; id_RegWrite = 1'b1; id_MemRead = 1'b1; end
            KSW:    begin id_ALUSrc = 1'b1; id_MemWrite = 1'b1; id_uses_rt = 1'b1;
                          id_RegDst = 1'($urandom); id_MemtoReg = 1'($urandom); end
            KBEQ:   begin id_ALUOp = 2'b01; id_Branch = 1'b1; id_uses_rt = 1'b1;
                          id_RegDst = 1'($urandom); id_MemtoReg = 1'($urandom); end
            KJ:     begin id_Branch = 1'b1; id_Jump = 1'b1;
                          id_RegDst = 1'($urandom); id_MemtoReg = 1'($urandom); end
            default: begin
                // Bubble carrying garbage control bits that must never be captured.
                id_valid = 1'b0;
                {id_RegDst, id_ALUSrc, id_ALUOp, id_MemtoReg, id_RegWrite, id_MemRead,
                 id_MemWrite, id_Branch, id_Jump, id_uses_rt} = 11'($urandom);
            end
        endcase
        id_rs = rs; id_rt = rt; id_rd = rd; mem_zero = mz;
    endtask

    // One ID cycle: drive inputs, queue the expected outputs, then advance the model past the edge.
    task automatic issue(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic mz);
        obs_t e;
        ctl_t d;
        logic f_m, h_m, s_m;
        @(negedge clk);
        drive_instr(kind, rs, rt, rd, mz);
        f_m = (pipe[1].Branch & mz) | pipe[1].Jump;
        h_m = id_valid & pipe[0].MemRead & (pipe[0].wreg != 5'd0) &
              ((pipe[0].wreg == rs) | (id_uses_rt & (pipe[0].wreg == rt)));
        s_m = h_m & ~f_m;
        e.ex_ALUSrc = pipe[0].ALUSrc;      e.ex_RegDst = pipe[0].RegDst;     e.ex_ALUOp = pipe[0].ALUOp;
        e.mem_MemRead = pipe[1].MemRead;   e.mem_MemWrite = pipe[1].MemWrite;
        e.wb_MemtoReg = pipe[2].MemtoReg;  e.wb_RegWrite = pipe[2].RegWrite; e.wb_wreg = pipe[2].wreg;
        e.stall = s_m;                     e.flush = f_m;
        e.stall_cnt = 16'((n_stall > 65535) ? 65535 : n_stall);
        e.flush_cnt = 16'((n_flush > 65535) ? 65535 : n_flush);
        e.s_stall_cnt = 2'((n_stall > 3) ? 3 : n_stall);
        e.s_flush_cnt = 2'((n_flush > 3) ? 3 : n_flush);
        exp_q.push_back(e);

        if (s_m) n_stall++;
        if (f_m) n_flush++;
        d = '{RegDst: id_RegDst, ALUSrc: id_ALUSrc, ALUOp: id_ALUOp, MemtoReg: id_MemtoReg,
              RegWrite: id_RegWrite, MemRead: id_MemRead, MemWrite: id_MemWrite,
              Branch: id_Branch, Jump: id_Jump,
              wreg: id_RegWrite ? (id_RegDst ? rd : rt) : 5'd0};
        pipe[2] = pipe[1];
        pipe[1] = f_m ? ctl_t'('0) : pipe[0];
        pipe[0] = (!id_valid || s_m || f_m) ? ctl_t'('0) : d;
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = sample();
        total++;
        if (a !== obs_t'('0)) begin
            bad++;
            $display("FAIL %s: outputs=%h required=0", name, a);
        end
    endtask

    // Asynchronous reset pulse placed between edges, with in-flight bundles.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        id_valid = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0;
        id_Branch = 1'b0; id_Jump = 1'b0;
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = sample();
                cyc++;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs cycle %0d: got ex{src=%b dst=%b op=%b} mem{rd=%b wr=%b} wb{m2r=%b rw=%b wreg=%0d} st=%b fl=%b sc=%0d fc=%0d ssc=%0d sfc=%0d; required ex{src=%b dst=%b op=%b} mem{rd=%b wr=%b} wb{m2r=%b rw=%b wreg=%0d} st=%b fl=%b sc=%0d fc=%0d ssc=%0d sfc=%0d",
                        cyc, a.ex_ALUSrc, a.ex_RegDst, a.ex_ALUOp, a.mem_MemRead, a.mem_MemWrite,
                        a.wb_MemtoReg, a.wb_RegWrite, a.wb_wreg, a.stall, a.flush, a.stall_cnt,
                        a.flush_cnt, a.s_stall_cnt, a.s_flush_cnt,
                        e.ex_ALUSrc, e.ex_RegDst, e.ex_ALUOp, e.mem_MemRead, e.mem_MemWrite,
                        e.wb_MemtoReg, e.wb_RegWrite, e.wb_wreg, e.stall, e.flush, e.stall_cnt,
                        e.flush_cnt, e.s_stall_cnt, e.s_flush_cnt);
                end
            end
        end
    end

    // Driver.
    initial begin
        model_reset();
        @(negedge clk);
        #1 check_zero("reset_state");
        rst = 1'b0;

        // R-format rd=5 then ADDIU rt=6.
        issue(KR, 5'd1, 5'd2, 5'd5, 1'b0);
        issue(KADDIU, 5'd3, 5'd6, 5'd0, 1'b0);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        // Load-use on $8, then LW to $0 with rs=0 (no hazard).
        issue(KLW, 5'd1, 5'd8, 5'd0, 1'b0);
        issue(KR, 5'd8, 5'd2, 5'd9, 1'b0);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        issue(KLW, 5'd1, 5'd0, 5'd0, 1'b0);
        issue(KR, 5'd0, 5'd0, 5'd3, 1'b0);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        // Taken BEQ squashes a younger SW and R-format.
        issue(KBEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(KSW, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(KR, 5'd1, 5'd2, 5'd7, 1'b1);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        // Not-taken BEQ.
        issue(KBEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(KR, 5'd1, 5'd2, 5'd7, 1'b0);
        issue(KR, 5'd1, 5'd2, 5'd4, 1'b0);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        // Jump with mem_zero low still squashes.
        issue(KJ, 5'd0, 5'd0, 5'd0, 1'b0);
        issue(KR, 5'd1, 5'd2, 5'd7, 1'b0);
        issue(KADDIU, 5'd1, 5'd3, 5'd0, 1'b0);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        // Hazard coinciding with a taken branch: flush wins.
        issue(KBEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(KLW, 5'd1, 5'd4, 5'd0, 1'b0);
        issue(KR, 5'd4, 5'd2, 5'd5, 1'b1);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);
        // Mid-stream reset.
        issue(KR, 5'd1, 5'd2, 5'd5, 1'b0);
        issue(KLW, 5'd1, 5'd5, 5'd0, 1'b0);
        issue(KJ, 5'd0, 5'd0, 5'd0, 1'b0);
        mid_reset();
        issue(KR, 5'd1, 5'd2, 5'd6, 1'b0);
        repeat (3) issue(KBUB, 5'd0, 5'd0, 5'd0, 1'b0);

        // Random stream over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            issue(int'($urandom_range(6, 0)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                  5'($urandom_range(3, 0)), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
